reg_file_2r1w: RTL and testbench

- 32-entry integer register file for the RISC-V datapath; sits directly upstream of the two 32:1 operand-read selectors and supplies rs1/rs2 operands to the ALU stage.
- One synchronous write port driven by the writeback stage.
- Two combinational read ports.
- Register x0 is hardwired to zero; an optional write-to-read bypass lets an operand see the value being written in the same cycle.

---
 rtl/reg_file_2r1w_if.sv | 24 ++
 rtl/reg_file_2r1w.sv | 61 ++++++
 tb/tb_reg_file_2r1w.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/reg_file_2r1w_if.sv
// Register-file access bus: one write port, two read ports, and the debug write counter.
// The master drives the addresses and write data. The slave returns the read data and wr_cnt.
interface reg_file_2r1w_if #(
    parameter int N = 32
);
    logic         we;
    logic [4:0]   wa;
    logic [N-1:0] wd;
    logic [4:0]   ra1;
    logic [4:0]   ra2;
    logic [N-1:0] rd1;
    logic [N-1:0] rd2;
    logic [7:0]   wr_cnt;

    modport master (
        output we, wa, wd, ra1, ra2,
        input  rd1, rd2, wr_cnt
    );

    modport slave (
        input  we, wa, wd, ra1, ra2,
        output rd1, rd2, wr_cnt
    );
endinterface

// File: rtl/reg_file_2r1w.sv
// 32-entry integer register file with one write port and two combinational read ports.
// x0 reads as zero, an optional write-to-read bypass is provided, and wr_cnt saturates.
module reg_file_2r1w #(
    parameter int N      = 32,
    parameter bit BYPASS = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    reg_file_2r1w_if.slave  bus
);

    logic [N-1:0] regs_reg [32];
    logic [7:0]   wr_cnt_reg;
    logic         wr_commit;

    // A write to x0 is discarded here, so it neither changes state nor counts.
    assign wr_commit = bus.we && (bus.wa != 5'd0);

    // Entry 0 is only ever cleared. The read path masks address 0 in any case.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                regs_reg[i] <= '0;
            end
        end else if (wr_commit) begin
            regs_reg[bus.wa] <= bus.wd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt_reg <= 8'd0;
        end else if (wr_commit && (wr_cnt_reg != 8'hFF)) begin
            wr_cnt_reg <= wr_cnt_reg + 8'd1;
        end
    end

    // Both read ports share identical logic and differ only in their address source.
    for (genvar gi = 0; gi < 2; gi++) begin : g_rd
        logic [4:0]   addr;
        logic [N-1:0] data;

        assign addr = (gi == 0) ? bus.ra1 : bus.ra2;

        always_comb begin
            data = '0;
            if (rst_n && (addr != 5'd0)) begin
                if (BYPASS && wr_commit && (addr == bus.wa)) begin
                    data = bus.wd;
                end else begin
                    data = regs_reg[addr];
                end
            end
        end
    end

    assign bus.rd1    = g_rd[0].data;
    assign bus.rd2    = g_rd[1].data;
    assign bus.wr_cnt = wr_cnt_reg;

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Scoreboard bench for reg_file_2r1w: a BYPASS=1 and a BYPASS=0 instance share all stimulus.
// Expectations are queued by the stimulus process and checked at each falling clock edge.
module tb_reg_file_2r1w;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    reg_file_2r1w_if #(.N(8)) bus1 ();
    reg_file_2r1w_if #(.N(8)) bus0 ();

    assign bus0.we  = bus1.we;
    assign bus0.wa  = bus1.wa;
    assign bus0.wd  = bus1.wd;
    assign bus0.ra1 = bus1.ra1;
    assign bus0.ra2 = bus1.ra2;

    reg_file_2r1w #(.N(8), .BYPASS(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    reg_file_2r1w #(.N(8), .BYPASS(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));

    typedef struct {
        string      name;
        bit         c1;
        logic [7:0] e1;
        bit         c2;
        logic [7:0] e2;
        bit         cc;
        logic [7:0] ec;
        bit         cn;
        logic [7:0] en;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic logic [7:0] val(input int i);
        return (i == 0) ? 8'h00 : 8'(i * 7 + 19);
    endfunction

    function automatic logic [7:0] sv(input int k);
        return 8'(k * 13 + 5);
    endfunction

    function automatic void push(input string name,
                                 input bit c1, input logic [7:0] e1,
                                 input bit c2, input logic [7:0] e2,
                                 input bit cc, input logic [7:0] ec,
                                 input bit cn, input logic [7:0] en);
        exp_t e;
        e.name = name; e.c1 = c1; e.e1 = e1; e.c2 = c2; e.e2 = e2;
        e.cc = cc; e.ec = ec; e.cn = cn; e.en = en;
        q.push_back(e);
    endfunction

    task automatic cmp(input string name, input string sig,
                       input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s %s actual=%h expected=%h t=%0t", name, sig, act, exp, $time);
        end
    endtask

    // Monitor: drain every expectation queued since the previous falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (q.size() > 0) begin
                e = q.pop_front();
                if (e.c1) cmp(e.name, "rd1", bus1.rd1, e.e1);
                if (e.c2) cmp(e.name, "rd2", bus1.rd2, e.e2);
                if (e.cc) cmp(e.name, "wr_cnt", bus1.wr_cnt, e.ec);
                if (e.cn) cmp(e.name, "rd1_nobypass", bus0.rd1, e.en);
                $display("txn %s t=%0t rd1=%h rd2=%h wr_cnt=%h rd1_nb=%h",
                         e.name, $time, bus1.rd1, bus1.rd2, bus1.wr_cnt, bus0.rd1);
            end
        end
    end

    task automatic drive(input logic we, input logic [4:0] wa, input logic [7:0] wd,
                         input logic [4:0] ra1, input logic [4:0] ra2);
        @(posedge clk);
        #1;
        bus1.we = we; bus1.wa = wa; bus1.wd = wd; bus1.ra1 = ra1; bus1.ra2 = ra2;
    endtask

    initial begin
        rst_n = 1'b0;
        bus1.we = 1'b0; bus1.wa = 5'd0; bus1.wd = 8'h00; bus1.ra1 = 5'd5; bus1.ra2 = 5'd9;
        #2;
        push("rst_init", 1, 8'h00, 1, 8'h00, 1, 8'h00, 1, 8'h00);
        @(negedge clk);
        #3;
        rst_n = 1'b1;

        // Load x5, then clear it with a short asynchronous reset pulse in the middle of a cycle.
        drive(1'b1, 5'd5, 8'hEF, 5'd5, 5'd0);
        drive(1'b0, 5'd0, 8'h00, 5'd5, 5'd0);
        push("x5_load", 1, 8'hEF, 1, 8'h00, 1, 8'd1, 1, 8'hEF);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        push("rst_during", 1, 8'h00, 1, 8'h00, 1, 8'h00, 0, 8'h00);
        #3;
        rst_n = 1'b1;
        push("rst_after", 1, 8'h00, 0, 8'h00, 1, 8'h00, 1, 8'h00);

        for (int i = 1; i < 32; i++) begin
            drive(1'b1, 5'(i), val(i), 5'd0, 5'd0);
        end
        for (int a = 0; a < 32; a++) begin
            drive(1'b0, 5'd0, 8'h00, 5'(a), 5'(31 - a));
            push($sformatf("sweep_%0d", a), 1, val(a), 1, val(31 - a), 1, 8'd31, 1, val(a));
        end

        drive(1'b1, 5'd0, 8'hFF, 5'd0, 5'd5);
        push("x0_pre", 1, 8'h00, 1, val(5), 1, 8'd31, 1, 8'h00);
        drive(1'b0, 5'd0, 8'h00, 5'd0, 5'd5);
        push("x0_post", 1, 8'h00, 1, val(5), 1, 8'd31, 1, 8'h00);

        drive(1'b1, 5'd7, 8'h11, 5'd7, 5'd7);
        push("byp_first", 1, 8'h11, 1, 8'h11, 1, 8'd31, 1, val(7));
        drive(1'b1, 5'd7, 8'h22, 5'd7, 5'd7);
        push("byp_pre", 1, 8'h22, 1, 8'h22, 1, 8'd32, 1, 8'h11);
        drive(1'b0, 5'd0, 8'h00, 5'd7, 5'd7);
        push("byp_post", 1, 8'h22, 1, 8'h22, 1, 8'd33, 1, 8'h22);

        // Reset is released in the same step as a clock edge: that edge must still see reset.
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        bus1.we = 1'b1; bus1.wa = 5'd3; bus1.wd = 8'hAB; bus1.ra1 = 5'd3; bus1.ra2 = 5'd7;
        push("race_in_rst", 1, 8'h00, 1, 8'h00, 1, 8'h00, 1, 8'h00);
        @(posedge clk);
        rst_n <= 1'b1;
        #1;
        bus1.we = 1'b0;
        push("race_edge", 1, 8'h00, 1, 8'h00, 1, 8'h00, 1, 8'h00);
        @(negedge clk);
        #1;
        bus1.we = 1'b1;
        drive(1'b0, 5'd0, 8'h00, 5'd3, 5'd0);
        push("race_commit", 1, 8'hAB, 1, 8'h00, 1, 8'd1, 1, 8'hAB);

        for (int k = 0; k < 300; k++) begin
            drive(1'b1, 5'd1, sv(k), 5'd1, 5'd3);
            if (k == 150) push("sat_mid", 1, sv(k), 1, 8'hAB, 1, 8'd151, 1, sv(k - 1));
            if (k == 253) push("sat_fe", 0, 8'h00, 0, 8'h00, 1, 8'hFE, 0, 8'h00);
            if (k == 254) push("sat_ff", 0, 8'h00, 0, 8'h00, 1, 8'hFF, 0, 8'h00);
            if (k == 299) push("sat_hold", 1, sv(k), 0, 8'h00, 1, 8'hFF, 1, sv(k - 1));
        end
        drive(1'b0, 5'd0, 8'h00, 5'd1, 5'd3);
        push("sat_end", 1, sv(299), 1, 8'hAB, 1, 8'hFF, 1, sv(299));

        drive(1'b0, 5'd0, 8'h00, 5'd0, 5'd0);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d pending expected=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
